voice_allocator: RTL and testbench

Polyphonic voice scheduler between the USB MIDI event stream and a bank of `NUM_VOICES` synthesizer DDS voices.
- Accepts 32-bit USB-MIDI event packets and decodes note-on, note-off and all-notes-off.
- Assigns each note to a voice: retrigger a matching voice, else take a free voice, else steal the least-recently-allocated one.
- Drives per-voice gate, note number, phase increment and retrigger pulse; the per-voice synthesizer instances consume these directly.

---
 rtl/voice_allocator_pkg.sv | 29 ++
 rtl/voice_allocator_note_phase_rom.sv | 39 +++
 rtl/voice_allocator.sv | 224 ++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_allocator_pkg.sv
// voice_allocator_pkg
// Shared constants and types for the polyphonic voice allocator:
// MIDI status nibbles, the all-notes-off controller number, synth sample
// rate and phase accumulator width, plus the allocator FSM state enum.
package voice_allocator_pkg;

  localparam int SYNTH_PHASE_ACC_BITS = 32;
  localparam int SYNTH_RATE           = 192000;

  localparam logic [3:0] MIDI_NOTE_ON     = 4'h9;
  localparam logic [3:0] MIDI_NOTE_OFF    = 4'h8;
  localparam logic [3:0] MIDI_CC          = 4'hB;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    LOOKUP,
    COMMIT
  } voice_alloc_state_t;

  // Decoded command held while a packet is in flight.
  typedef enum logic [1:0] {
    CMD_NOTE_ON,
    CMD_NOTE_OFF,
    CMD_ALL_OFF
  } voice_cmd_t;

endpackage

// File: rtl/voice_allocator_note_phase_rom.sv
// note_phase_rom
// 128-entry MIDI-note to DDS phase-increment table with a registered read
// (one cycle latency). Entry n = round(440 * 2^((n-69)/12) * 2^PHASE_BITS
// / SYNTH_RATE), evaluated at elaboration time.
// Ports:
//   clk   in  1           clock
//   addr  in  7           MIDI note number
//   data  out PHASE_BITS  phase increment for addr, one cycle later
module note_phase_rom
  import voice_allocator_pkg::*;
#(
  parameter int PHASE_BITS = SYNTH_PHASE_ACC_BITS
) (
  input  logic                  clk,
  input  logic [6:0]            addr,
  output logic [PHASE_BITS-1:0] data
);

  function automatic logic [PHASE_BITS-1:0] note_incr(input int n);
    real freq;
    real scaled;
    freq   = 440.0 * (2.0 ** ((real'(n) - 69.0) / 12.0));
    scaled = freq * (2.0 ** PHASE_BITS) / real'(SYNTH_RATE);
    return PHASE_BITS'(longint'($floor(scaled + 0.5)));
  endfunction

  logic [PHASE_BITS-1:0] rom [128];

  genvar gi;
  for (gi = 0; gi < 128; gi++) begin : g_rom
    localparam logic [PHASE_BITS-1:0] ENTRY = note_incr(gi);
    assign rom[gi] = ENTRY;
  end

  always_ff @(posedge clk) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator
// Polyphonic voice scheduler: decodes USB-MIDI note-on / note-off /
// all-notes-off packets and assigns notes to NUM_VOICES DDS voices
// (retrigger matching voice, else lowest free voice, else optionally steal
// the least-recently-allocated voice).
// Build option: define VOICE_ALLOC_STEAL_EN to enable voice stealing;
// without it a note-on finding no match and no free voice is dropped.
// Ports:
//   clk_in            in  1                      clock
//   rst_in            in  1                      synchronous active-high reset
//   midi_in           in  32                     {cable/CIN, status, data1, data2}
//   midi_valid_in     in  1                      packet present
//   midi_ready_out    out 1                      high in IDLE (can accept)
//   voice_active_out  out NUM_VOICES             gate per voice
//   voice_note_out    out 7*NUM_VOICES           note per voice, voice i at [7i+6:7i]
//   phase_incr_out    out PHASE_BITS*NUM_VOICES  DDS increment per voice
//   voice_trig_out    out NUM_VOICES             one-cycle (re)trigger pulse
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_BITS = SYNTH_PHASE_ACC_BITS
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [31:0]                      midi_in,
  input  logic                             midi_valid_in,
  output logic                             midi_ready_out,
  output logic [NUM_VOICES-1:0]            voice_active_out,
  output logic [7*NUM_VOICES-1:0]          voice_note_out,
  output logic [PHASE_BITS*NUM_VOICES-1:0] phase_incr_out,
  output logic [NUM_VOICES-1:0]            voice_trig_out
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  voice_alloc_state_t    state_reg;
  voice_cmd_t            cmd_reg;
  logic [6:0]            pkt_note_reg;
  logic [IDX_W-1:0]      scan_idx_reg;
  logic [IDX_W-1:0]      match_idx_reg, free_idx_reg, target_reg;
  logic                  match_found_reg, free_found_reg, hit_reg;
  logic [NUM_VOICES-1:0] active_reg, trig_reg;
  logic [6:0]            voice_note_reg [NUM_VOICES];
  logic [PHASE_BITS-1:0] incr_reg       [NUM_VOICES];
  logic [IDX_W-1:0]      rank_reg       [NUM_VOICES];
  logic [PHASE_BITS-1:0] rom_data;

  logic                  match_found_next, free_found_next;
  logic [IDX_W-1:0]      match_idx_next, free_idx_next;
`ifdef VOICE_ALLOC_STEAL_EN
  logic [IDX_W-1:0]      oldest_idx_reg, oldest_idx_next;
`endif

  // Packet decode (channel nibble and cable/CIN are don't-care).
  logic [3:0] status_hi;
  logic [7:0] data1, data2;
  logic       is_note_on, is_note_off, is_all_off;
  logic       unused_bits;

  assign status_hi   = midi_in[23:20];
  assign data1       = midi_in[15:8];
  assign data2       = midi_in[7:0];
  assign is_note_on  = (status_hi == MIDI_NOTE_ON) && (data2 != 8'd0);
  assign is_note_off = ((status_hi == MIDI_NOTE_ON) && (data2 == 8'd0)) ||
                       (status_hi == MIDI_NOTE_OFF);
  assign is_all_off  = (status_hi == MIDI_CC) && (data1 == {1'b0, CC_ALL_NOTES_OFF});
  assign unused_bits = ^{midi_in[31:24], midi_in[19:16]};

  // ROM address is the latched note; it is stable from accept through
  // COMMIT, so the registered ROM output is valid by the time it is used.
  note_phase_rom #(.PHASE_BITS(PHASE_BITS)) u_rom (
    .clk  (clk_in),
    .addr (pkt_note_reg),
    .data (rom_data)
  );

  // Running scan records including the voice examined this cycle, so the
  // decision on the last scan cycle already sees voice NUM_VOICES-1.
  always_comb begin
    match_found_next = match_found_reg;
    match_idx_next   = match_idx_reg;
    free_found_next  = free_found_reg;
    free_idx_next    = free_idx_reg;
    if (!match_found_reg && active_reg[scan_idx_reg] &&
        (voice_note_reg[scan_idx_reg] == pkt_note_reg)) begin
      match_found_next = 1'b1;
      match_idx_next   = scan_idx_reg;
    end
    if (!free_found_reg && !active_reg[scan_idx_reg]) begin
      free_found_next = 1'b1;
      free_idx_next   = scan_idx_reg;
    end
  end

`ifdef VOICE_ALLOC_STEAL_EN
  always_comb begin
    oldest_idx_next = oldest_idx_reg;
    if (rank_reg[scan_idx_reg] == LAST_IDX) begin
      oldest_idx_next = scan_idx_reg;
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg       <= IDLE;
      cmd_reg         <= CMD_NOTE_ON;
      pkt_note_reg    <= '0;
      scan_idx_reg    <= '0;
      match_idx_reg   <= '0;
      free_idx_reg    <= '0;
      target_reg      <= '0;
      match_found_reg <= 1'b0;
      free_found_reg  <= 1'b0;
      hit_reg         <= 1'b0;
      active_reg      <= '0;
      trig_reg        <= '0;
`ifdef VOICE_ALLOC_STEAL_EN
      oldest_idx_reg  <= '0;
`endif
      for (int j = 0; j < NUM_VOICES; j++) begin
        voice_note_reg[j] <= '0;
        incr_reg[j]       <= '0;
        rank_reg[j]       <= IDX_W'(j);
      end
    end else begin
      trig_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (midi_valid_in) begin
            pkt_note_reg    <= data1[6:0];
            scan_idx_reg    <= '0;
            match_found_reg <= 1'b0;
            free_found_reg  <= 1'b0;
            if (is_note_on) begin
              cmd_reg   <= CMD_NOTE_ON;
              state_reg <= SCAN;
            end else if (is_note_off) begin
              cmd_reg   <= CMD_NOTE_OFF;
              state_reg <= SCAN;
            end else if (is_all_off) begin
              cmd_reg   <= CMD_ALL_OFF;
              state_reg <= COMMIT;
            end
          end
        end

        SCAN: begin
          match_found_reg <= match_found_next;
          match_idx_reg   <= match_idx_next;
          free_found_reg  <= free_found_next;
          free_idx_reg    <= free_idx_next;
`ifdef VOICE_ALLOC_STEAL_EN
          oldest_idx_reg  <= oldest_idx_next;
`endif
          scan_idx_reg    <= scan_idx_reg + 1'b1;
          if (scan_idx_reg == LAST_IDX) begin
            if (cmd_reg == CMD_NOTE_OFF) begin
              // Note-off always commits; hit_reg gates the actual change.
              hit_reg    <= match_found_next;
              target_reg <= match_idx_next;
              state_reg  <= COMMIT;
            end else if (match_found_next) begin
              target_reg <= match_idx_next;
              state_reg  <= LOOKUP;
            end else if (free_found_next) begin
              target_reg <= free_idx_next;
              state_reg  <= LOOKUP;
            end else begin
`ifdef VOICE_ALLOC_STEAL_EN
              target_reg <= oldest_idx_next;
              state_reg  <= LOOKUP;
`else
              state_reg  <= IDLE;
`endif
            end
          end
        end

        LOOKUP: begin
          state_reg <= COMMIT;
        end

        COMMIT: begin
          if (cmd_reg == CMD_NOTE_ON) begin
            active_reg[target_reg]     <= 1'b1;
            trig_reg[target_reg]       <= 1'b1;
            voice_note_reg[target_reg] <= pkt_note_reg;
            incr_reg[target_reg]       <= rom_data;
            // Age every voice younger than the target; target becomes newest.
            for (int j = 0; j < NUM_VOICES; j++) begin
              if (rank_reg[j] < rank_reg[target_reg]) begin
                rank_reg[j] <= rank_reg[j] + 1'b1;
              end
            end
            rank_reg[target_reg] <= '0;
          end else if (cmd_reg == CMD_NOTE_OFF) begin
            if (hit_reg) begin
              active_reg[target_reg] <= 1'b0;
            end
          end else begin
            active_reg <= '0;
          end
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign midi_ready_out   = (state_reg == IDLE);
  assign voice_active_out = active_reg;
  assign voice_trig_out   = trig_reg;

  genvar gi;
  for (gi = 0; gi < NUM_VOICES; gi++) begin : g_out
    assign voice_note_out[7*gi +: 7]                   = voice_note_reg[gi];
    assign phase_incr_out[PHASE_BITS*gi +: PHASE_BITS] = incr_reg[gi];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Testbench for voice_allocator (NUM_VOICES=4, PHASE_BITS=32).
// Stimulus tasks push the hand-computed expected voice state for each
// packet into a queue; a monitor pops an entry each time ready rises
// (transaction complete) and compares outputs and latency.
module tb_voice_allocator;

  localparam logic [31:0] INC60 = 32'd5852465;
  localparam logic [31:0] INC62 = 32'd6569170;
  localparam logic [31:0] INC64 = 32'd7373644;
  localparam logic [31:0] INC65 = 32'd7812103;
  localparam logic [31:0] INC67 = 32'd8768789;
  localparam logic [31:0] INC69 = 32'd9842633;
  localparam logic [31:0] INC71 = 32'd11047982;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic [31:0]  midi_in = '0;
  logic         midi_valid_in = 1'b0;
  logic         midi_ready_out;
  logic [3:0]   voice_active_out;
  logic [27:0]  voice_note_out;
  logic [127:0] phase_incr_out;
  logic [3:0]   voice_trig_out;

  voice_allocator #(.NUM_VOICES(4), .PHASE_BITS(32)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .midi_in          (midi_in),
    .midi_valid_in    (midi_valid_in),
    .midi_ready_out   (midi_ready_out),
    .voice_active_out (voice_active_out),
    .voice_note_out   (voice_note_out),
    .phase_incr_out   (phase_incr_out),
    .voice_trig_out   (voice_trig_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]   act;
    logic [27:0]  note;
    logic [127:0] incr;
    logic [3:0]   trig;
    int           lat;   // 0: latency not checked
    int           acc;   // cycle number of the accept edge
    string        name;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Hand-maintained expected voice state.
  logic [3:0]  e_act = '0;
  logic [3:0]  e_trig = '0;
  logic [6:0]  e_note [4] = '{default: '0};
  logic [31:0] e_incr [4] = '{default: '0};

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic exp_t snap(input int lat, input string name);
    exp_t e;
    e.act = e_act;
    e.trig = e_trig;
    e.lat = lat;
    e.acc = 0;
    e.name = name;
    for (int i = 0; i < 4; i++) begin
      e.note[7*i +: 7]  = e_note[i];
      e.incr[32*i +: 32] = e_incr[i];
    end
    return e;
  endfunction

  // Monitor: a rising ready marks a completed transaction.
  logic ready_prev = 1'b1;
  logic trig_clear_pending = 1'b0;
  always @(negedge clk_in) begin
    exp_t e;
    if (trig_clear_pending) begin
      trig_clear_pending = 1'b0;
      chk("trig_one_cycle", voice_trig_out, 4'b0000);
    end
    if (midi_ready_out === 1'b1 && ready_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_completion", 1, 0);
      end else begin
        e = exp_q.pop_front();
        if (e.lat != 0) chk({e.name, ".latency"}, cyc - e.acc + 1, e.lat);
        chk({e.name, ".active"}, voice_active_out, e.act);
        chk({e.name, ".note"}, voice_note_out, e.note);
        chk({e.name, ".incr"}, phase_incr_out, e.incr);
        chk({e.name, ".trig"}, voice_trig_out, e.trig);
        $display("txn %s done: active=%b trig=%b notes=%h", e.name,
                 voice_active_out, voice_trig_out, voice_note_out);
        trig_clear_pending = 1'b1;
      end
    end
    ready_prev = midi_ready_out;
  end

  task automatic send(input logic [31:0] pkt, input int lat, input string name);
    exp_t e;
    int n;
    e = snap(lat, name);
    @(negedge clk_in);
    midi_in = pkt;
    midi_valid_in = 1'b1;
    n = 0;
    while (midi_ready_out !== 1'b1 && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    if (midi_ready_out !== 1'b1) begin
      chk({name, ".ready_timeout"}, 0, 1);
      midi_valid_in = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk_in);
    #1 midi_valid_in = 1'b0;
  endtask

  task automatic send_ignored(input logic [31:0] pkt, input string name);
    @(negedge clk_in);
    midi_in = pkt;
    midi_valid_in = 1'b1;
    @(posedge clk_in);
    #1 midi_valid_in = 1'b0;
    @(negedge clk_in);
    chk({name, ".ready"}, midi_ready_out, 1);
    chk({name, ".active"}, voice_active_out, e_act);
    $display("txn %s ignored: ready=%b active=%b", name, midi_ready_out, voice_active_out);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || midi_ready_out !== 1'b1) && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    if (exp_q.size() != 0) chk("idle_timeout", exp_q.size(), 0);
    @(negedge clk_in);
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("reset.ready_during", midi_ready_out, 1);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("reset.active", voice_active_out, 4'b0);
    chk("reset.note", voice_note_out, 28'b0);
    chk("reset.incr", phase_incr_out, 128'b0);
    chk("reset.trig", voice_trig_out, 4'b0);
    chk("reset.ready", midi_ready_out, 1);
    e_act = '0;
    e_trig = '0;
    for (int i = 0; i < 4; i++) begin
      e_note[i] = '0;
      e_incr[i] = '0;
    end
    $display("txn reset: ready=%b active=%b", midi_ready_out, voice_active_out);
  endtask

  initial begin
    apply_reset();

    // Single note-on A4 lands on voice 0.
    e_act[0] = 1'b1; e_note[0] = 7'd69; e_incr[0] = INC69; e_trig = 4'b0001;
    send(32'h0990_4564, 7, "on69");
    wait_idle();
    apply_reset();

    // Fill all four voices, then a fifth note.
    e_act[0] = 1'b1; e_note[0] = 7'd60; e_incr[0] = INC60; e_trig = 4'b0001;
    send(32'h0990_3C64, 7, "on60");
    e_act[1] = 1'b1; e_note[1] = 7'd62; e_incr[1] = INC62; e_trig = 4'b0010;
    send(32'h0990_3E64, 7, "on62");
    e_act[2] = 1'b1; e_note[2] = 7'd64; e_incr[2] = INC64; e_trig = 4'b0100;
    send(32'h0990_4064, 7, "on64");
    e_act[3] = 1'b1; e_note[3] = 7'd65; e_incr[3] = INC65; e_trig = 4'b1000;
    send(32'h0990_4164, 7, "on65");
`ifdef VOICE_ALLOC_STEAL_EN
    e_note[0] = 7'd67; e_incr[0] = INC67; e_trig = 4'b0001;
    send(32'h0990_4364, 7, "on67_steal");
`else
    e_trig = 4'b0000;
    send(32'h0990_4364, 5, "on67_drop");
`endif

    // Note-off 62, then note-on 71 reuses the freed voice.
    e_act[1] = 1'b0; e_trig = 4'b0000;
    send(32'h0880_3E40, 6, "off62");
    e_act[1] = 1'b1; e_note[1] = 7'd71; e_incr[1] = INC71; e_trig = 4'b0010;
    send(32'h0990_4764, 7, "on71");

    // Velocity-0 note-on acts as note-off; off for silent notes changes nothing.
    e_act[2] = 1'b0; e_trig = 4'b0000;
    send(32'h0990_4000, 6, "vel0_64");
    send(32'h0880_3240, 6, "off50_none");
    send(32'h0880_4040, 6, "off64_inactive");
    wait_idle();
    send_ignored(32'h0BB0_0764, "cc7");
    send_ignored(32'h0EE0_0040, "bend");

    // Reactivate voice 2, retrigger 71, then all-notes-off.
    e_act[2] = 1'b1; e_trig = 4'b0100;
    send(32'h0990_4064, 7, "on64_again");
    e_trig = 4'b0010;
    send(32'h0990_4764, 7, "retrig71");
    e_act = 4'b0000; e_trig = 4'b0000;
    send(32'h0BB0_7B00, 2, "all_off");

    // Back-to-back: second packet is held while the first is scanning.
    e_act[0] = 1'b1; e_note[0] = 7'd60; e_incr[0] = INC60; e_trig = 4'b0001;
    send(32'h0990_3C64, 7, "on60_b");
    e_act[1] = 1'b1; e_note[1] = 7'd62; e_incr[1] = INC62; e_trig = 4'b0010;
    send(32'h0990_3E64, 7, "on62_held");
    wait_idle();

    // Reset during SCAN discards the packet and restores reset values.
    e_act = '0; e_trig = '0;
    for (int i = 0; i < 4; i++) begin
      e_note[i] = '0;
      e_incr[i] = '0;
    end
    send(32'h0990_4064, 0, "reset_mid_scan");
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("mid_reset.ready", midi_ready_out, 1);
    wait_idle();

    e_act[0] = 1'b1; e_note[0] = 7'd69; e_incr[0] = INC69; e_trig = 4'b0001;
    send(32'h0990_4564, 7, "on69_after_reset");
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
